oscillator_voice: RTL and testbench
===================================

// Module: oscillator_voice
// PURPOSE
//  Single-voice phase-accumulator oscillator; the stage directly upstream of the envelope follower.
//  Generates the sample-rate strobe, a 12-bit unsigned waveform and the voice playing flag
//  (feeds inSample / inSampleReady / inIsPlaying downstream). Note gate comes from the MIDI/voice allocator.
// PARAMETERS
//  SAMPLE_DIV  1024  clocks per sample tick (>=2)
//  PHASE_W     24    phase accumulator width (>=14)
// PORTS
//  inClk          in   1        system clock; all logic on rising edge
//  inReset        in   1        asynchronous, active-high reset
//  inNoteOn       in   1        note gate level
//  inPhaseInc     in   PHASE_W  phase increment per sample (pitch)
//  inWaveSel      in   2        00 saw, 01 square, 10 triangle, 11 noise/silence
//  outSample      out  12       unsigned sample, midpoint 12'h800 = silence
//  outSampleReady out  1        1-cycle strobe: new outSample valid
//  outIsPlaying   out  1        high in RUN and STOP
// BEHAVIOUR
//  Reset: tick counter 0, phase 0, state IDLE, outSample 12'h800, outSampleReady 0, outIsPlaying 0, lfsr 15'h0001.
//  Tick: counter counts 0..SAMPLE_DIV-1 and wraps; tick = counter==SAMPLE_DIV-1. Ticks run in every state.
//  All state/phase/output updates happen only on tick edges; inNoteOn, inPhaseInc and inWaveSel are sampled there.
//  outSampleReady = 1 for exactly the cycle after each tick edge (registered with outSample); latency 1 clk.
//  wave(p): T = p[PHASE_W-1 -: 12]; saw = T; square = p[MSB] ? 12'hFFF : 12'h000;
//    tri = p[MSB] ? ~p[PHASE_W-2 -: 12] : p[PHASE_W-2 -: 12]; sel 11 see CONFIGURATION.
//  FSM, evaluated at tick, in priority order:
//   IDLE: outSample<=800. If inNoteOn: ->RUN, phase<=0.
//   RUN : outSample<=wave(phase), phase<=phase+inc (mod 2^PHASE_W). If !inNoteOn: ->STOP.
//   STOP: if inNoteOn: ->RUN, phase<=0 (retrigger), outSample<=wave(phase).
//         else outSample<=wave(phase); sum=phase+inc; carry out or inc==0 -> IDLE, phase<=0;
//         otherwise phase<=sum. Gives click-free release at a cycle boundary.
//  outIsPlaying registered at tick edge = (next state != IDLE).
//  Gate pulses shorter than one tick period are ignored (level sampled only at tick).
//  Reset mid-operation: all outputs go to reset values immediately (async); first strobe SAMPLE_DIV clks after release.
//  inPhaseInc change mid-note takes effect at next tick; no phase reset.
// CONFIGURATION
//  OSCILLATOR_NOISE_EN defined: sel 11 = noise; outSample<=lfsr[11:0] (pre-advance value);
//    15-bit LFSR, shift left, new bit0 = lfsr[14]^lfsr[13]; advances only on ticks in RUN or STOP.
//  Not defined: no LFSR logic; sel 11 in RUN/STOP outputs 12'h800; phase still advances.
// TESTING  (SAMPLE_DIV=4, PHASE_W=24)
//  Reset asserted mid-RUN -> same cycle outSample=800, outSampleReady=0, outIsPlaying=0; strobe 4 clks after release.
//  Saw, inc=2^20, gate=1 from reset -> strobes every 4 clks: 800 (IDLE tick), 000, 100, 200, 300...; outIsPlaying=1 after first tick.
//  Square, inc=2^22 -> 800, 000, 000, FFF, FFF, 000.
//  Triangle, inc=2^21 -> 800, 000, 400, 800, C00, FFF, BFF, 7FF, 3FF, 000.
//  Saw inc=2^22, drop gate before tick with phase=2^23 -> 800, C00 (carry, ->IDLE, outIsPlaying=0), then 800s; re-raise gate during STOP -> restart at 000.
//  OSCILLATOR_NOISE_EN, sel=11, gate=1 -> 800, then 001, 002, 004 ... 800 (12 samples); undefined -> all 800, outIsPlaying=1.

Source files
------------

// File: rtl/oscillator_voice.sv
// oscillator_voice: single-voice phase-accumulator oscillator.
//
// A free-running divider produces one sample tick every SAMPLE_DIV clocks.
// On each tick the voice FSM samples the gate, pitch and waveform inputs,
// produces a new 12-bit unsigned sample and advances the phase accumulator.
// On note release the phase runs on until it wraps, so the voice stops
// at a cycle boundary and does not click.
//
// Optional feature: define OSCILLATOR_NOISE_EN to make waveform select 11
// a 15-bit LFSR noise source. Without it, select 11 outputs silence (12'h800).
//
// Ports:
//   inClk          system clock, rising edge
//   inReset        asynchronous active-high reset
//   inNoteOn       note gate level, sampled at ticks
//   inPhaseInc     phase increment per sample (pitch)
//   inWaveSel      00 saw, 01 square, 10 triangle, 11 noise/silence
//   outSample      unsigned sample, 12'h800 = silence
//   outSampleReady one-cycle strobe marking a new outSample
//   outIsPlaying   high while the voice is running or releasing
module oscillator_voice #(
  parameter int unsigned SAMPLE_DIV = 1024,
  parameter int unsigned PHASE_W    = 24
) (
  input  logic               inClk,
  input  logic               inReset,
  input  logic               inNoteOn,
  input  logic [PHASE_W-1:0] inPhaseInc,
  input  logic [1:0]         inWaveSel,
  output logic [11:0]        outSample,
  output logic               outSampleReady,
  output logic               outIsPlaying
);

  localparam int unsigned    CntW    = $clog2(SAMPLE_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(SAMPLE_DIV - 1);
  localparam logic [11:0]    Silence = 12'h800;

  typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic [PHASE_W-1:0] phase_q;
  logic               tick;
  logic [PHASE_W:0]   phase_sum;
  logic               stop_done;
  logic [11:0]        wave;
  logic [11:0]        tri_mag;

  // Sample-rate divider, runs in every state.
  always_ff @(posedge inClk or posedge inReset) begin
    if (inReset) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign tick = (cnt_q == CntMax);

  // Extra top bit catches the accumulator wrapping.
  assign phase_sum = {1'b0, phase_q} + {1'b0, inPhaseInc};
  // A zero increment would never wrap, so release ends immediately.
  assign stop_done = phase_sum[PHASE_W] | (inPhaseInc == '0);

`ifdef OSCILLATOR_NOISE_EN
  logic [14:0] lfsr_q;

  always_ff @(posedge inClk or posedge inReset) begin
    if (inReset) begin
      lfsr_q <= 15'h0001;
    end else if (tick && (state_q == StRun || state_q == StStop)) begin
      lfsr_q <= {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
    end
  end
`endif

  // Triangle folds the phase below the MSB: rising in the first half, falling in the second.
  assign tri_mag = phase_q[PHASE_W-2 -: 12];

  always_comb begin
    wave = Silence;
    unique case (inWaveSel)
      2'b00: wave = phase_q[PHASE_W-1 -: 12];
      2'b01: wave = phase_q[PHASE_W-1] ? 12'hFFF : 12'h000;
      2'b10: wave = phase_q[PHASE_W-1] ? ~tri_mag : tri_mag;
`ifdef OSCILLATOR_NOISE_EN
      2'b11: wave = lfsr_q[11:0];
`else
      2'b11: wave = Silence;
`endif
      default: wave = Silence;
    endcase
  end

  // Voice FSM; everything except the strobe changes only on tick edges.
  always_ff @(posedge inClk or posedge inReset) begin
    if (inReset) begin
      state_q        <= StIdle;
      phase_q        <= '0;
      outSample      <= Silence;
      outSampleReady <= 1'b0;
      outIsPlaying   <= 1'b0;
    end else begin
      outSampleReady <= tick;
      if (tick) begin
        unique case (state_q)
          StIdle: begin
            outSample    <= Silence;
            outIsPlaying <= inNoteOn;
            if (inNoteOn) begin
              state_q <= StRun;
              phase_q <= '0;
            end
          end
          StRun: begin
            outSample    <= wave;
            phase_q      <= phase_sum[PHASE_W-1:0];
            outIsPlaying <= 1'b1;
            if (!inNoteOn) begin
              state_q <= StStop;
            end
          end
          StStop: begin
            outSample <= wave;
            if (inNoteOn) begin
              state_q      <= StRun;
              phase_q      <= '0;
              outIsPlaying <= 1'b1;
            end else if (stop_done) begin
              state_q      <= StIdle;
              phase_q      <= '0;
              outIsPlaying <= 1'b0;
            end else begin
              phase_q      <= phase_sum[PHASE_W-1:0];
              outIsPlaying <= 1'b1;
            end
          end
          default: begin
            state_q      <= StIdle;
            phase_q      <= '0;
            outSample    <= Silence;
            outIsPlaying <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oscillator_voice.sv
// Directed bench for oscillator_voice with SAMPLE_DIV=4, PHASE_W=24.
module tb_oscillator_voice;

  localparam int unsigned PhaseW = 24;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              note_on = 1'b0;
  logic [PhaseW-1:0] phase_inc = '0;
  logic [1:0]        wave_sel = 2'b00;
  logic [11:0]       sample;
  logic              sample_ready;
  logic              is_playing;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] tri_exp [10] = '{12'h800, 12'h000, 12'h400, 12'h800, 12'hC00,
                                12'hFFF, 12'hBFF, 12'h7FF, 12'h3FF, 12'h000};

  always #5 clk = ~clk;

  oscillator_voice #(
    .SAMPLE_DIV(4),
    .PHASE_W   (PhaseW)
  ) dut (
    .inClk         (clk),
    .inReset       (rst),
    .inNoteOn      (note_on),
    .inPhaseInc    (phase_inc),
    .inWaveSel     (wave_sel),
    .outSample     (sample),
    .outSampleReady(sample_ready),
    .outIsPlaying  (is_playing)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the next strobe; clks = negedges waited.
  task automatic next_sample(output logic [11:0] s, output int clks);
    s    = 'x;
    clks = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (sample_ready === 1'b1) begin
        s    = sample;
        clks = i;
        return;
      end
    end
    check_value("strobe_timeout", 0, 1);
  endtask

  task automatic expect_sample(input string tag, input logic [11:0] exp);
    logic [11:0] s;
    int          clks;
    next_sample(s, clks);
    check_value(tag, {20'h0, s}, {20'h0, exp});
  endtask

  task automatic do_reset(input logic note, input logic [PhaseW-1:0] inc, input logic [1:0] sel);
    @(negedge clk);
    rst = 1'b1;
    note_on   = note;
    phase_inc = inc;
    wave_sel  = sel;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [11:0] s;
    int          clks;

    // Reset state
    @(negedge clk);
    check_value("rst_sample", {20'h0, sample}, 32'h800);
    check_value("rst_ready", {31'h0, sample_ready}, 0);
    check_value("rst_playing", {31'h0, is_playing}, 0);

    // Saw, inc=2^20, gate high from reset
    do_reset(1'b1, 24'h100000, 2'b00);
    next_sample(s, clks);
    check_value("first_strobe_latency", clks, 4);
    check_value("saw_idle", {20'h0, s}, 32'h800);
    check_value("saw_playing_after_tick", {31'h0, is_playing}, 1);
    for (int i = 0; i < 4; i++) begin
      next_sample(s, clks);
      check_value("saw_value", {20'h0, s}, i * 32'h100);
      check_value("saw_period", clks, 4);
    end
    // Pitch change mid-note: no phase reset
    phase_inc = 24'h400000;
    expect_sample("inc_change_0", 12'h400);
    expect_sample("inc_change_1", 12'h800);

    // Reset asserted mid-RUN during a strobe cycle
    next_sample(s, clks);
    #1 rst = 1'b1;
    #1;
    check_value("midrst_sample", {20'h0, sample}, 32'h800);
    check_value("midrst_ready", {31'h0, sample_ready}, 0);
    check_value("midrst_playing", {31'h0, is_playing}, 0);
    @(negedge clk);
    rst = 1'b0;
    next_sample(s, clks);
    check_value("midrst_strobe_latency", clks, 4);

    // Square, inc=2^22
    do_reset(1'b1, 24'h400000, 2'b01);
    expect_sample("sq_0", 12'h800);
    expect_sample("sq_1", 12'h000);
    expect_sample("sq_2", 12'h000);
    expect_sample("sq_3", 12'hFFF);
    expect_sample("sq_4", 12'hFFF);
    expect_sample("sq_5", 12'h000);

    // Triangle, inc=2^21
    do_reset(1'b1, 24'h200000, 2'b10);
    for (int i = 0; i < 10; i++) expect_sample("tri", tri_exp[i]);

    // Release with carry: saw inc=2^22, gate dropped when phase=2^23
    do_reset(1'b1, 24'h400000, 2'b00);
    expect_sample("rel_0", 12'h800);
    expect_sample("rel_1", 12'h000);
    expect_sample("rel_2", 12'h400);
    note_on = 1'b0;
    expect_sample("rel_3", 12'h800);
    check_value("rel_playing_stop", {31'h0, is_playing}, 1);
    expect_sample("rel_4", 12'hC00);
    check_value("rel_playing_idle", {31'h0, is_playing}, 0);
    expect_sample("rel_5", 12'h800);
    // Gate pulse shorter than a tick period is ignored
    note_on = 1'b1;
    @(negedge clk);
    note_on = 1'b0;
    expect_sample("short_pulse", 12'h800);
    check_value("short_pulse_playing", {31'h0, is_playing}, 0);

    // Retrigger during STOP: inc=2^20
    do_reset(1'b1, 24'h100000, 2'b00);
    expect_sample("retrig_0", 12'h800);
    expect_sample("retrig_1", 12'h000);
    expect_sample("retrig_2", 12'h100);
    note_on = 1'b0;
    expect_sample("retrig_3", 12'h200);
    expect_sample("retrig_4", 12'h300);
    check_value("retrig_stop_playing", {31'h0, is_playing}, 1);
    note_on = 1'b1;
    expect_sample("retrig_5", 12'h400);
    expect_sample("retrig_6", 12'h000);
    expect_sample("retrig_7", 12'h100);

    // Select 11: noise when enabled, silence otherwise
    do_reset(1'b1, 24'h100000, 2'b11);
    expect_sample("noise_idle", 12'h800);
    for (int i = 0; i < 12; i++) begin
`ifdef OSCILLATOR_NOISE_EN
      expect_sample("noise", 12'(1 << i));
`else
      expect_sample("noise_silent", 12'h800);
`endif
      check_value("noise_playing", {31'h0, is_playing}, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
